gumnut_port_responder: RTL and testbench
========================================

GUMNUT_PORT_RESPONDER -- requirements
Module: gumnut_port_responder

Interface
REQ-001 Parameter DW, default 8: port data width.
REQ-002 Parameter AW, default 8: port address width.
REQ-003 Parameter DEPTH, default 32: input-buffer entries, power of two, minimum 2.
REQ-004 Parameter WAIT, default 0: idle cycles between request detection and ack, range 0..15.
REQ-005 Parameter INT_PERIOD, default 25: idle cycles before each interrupt request, minimum 1.
REQ-006 Parameter INT_COUNT, default 10: number of interrupts to issue; 0 means unlimited.
REQ-007 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-008 rst_i  in  1  reset, asynchronous, active-low.
REQ-009 port_cyc_i, port_stb_i, port_we_i  in  1 each  bus cycle, strobe, write-enable from the CPU.
REQ-010 port_adr_i  in  AW  port address.
REQ-011 port_dat_i  in  DW  CPU write data.
REQ-012 port_dat_o  out  DW  read data returned to the CPU.
REQ-013 port_ack_o  out  1  transfer acknowledge.
REQ-014 int_req_o  out  1  interrupt request; int_ack_i  in  1  CPU interrupt acknowledge.
REQ-015 load_we_i  in  1, load_adr_i  in  clog2(DEPTH), load_dat_i  in  DW  buffer preload port.
REQ-016 wr_valid_o  out  1, wr_adr_o  out  AW, wr_dat_o  out  DW  captured CPU write.
REQ-017 int_done_o  out  1  high once INT_COUNT interrupts have completed.

Function
REQ-018 Bus FSM states: IDLE, WAIT, ACK; a request is cyc&stb sampled high in IDLE.
REQ-019 IDLE->ACK when a request is sampled and WAIT=0; IDLE->WAIT when WAIT>0, with wait counter loaded to WAIT-1.
REQ-020 WAIT counts down to 0, then ->ACK; if cyc or stb drops during WAIT -> IDLE, with no ack and no pointer change.
REQ-021 ACK lasts exactly one cycle with port_ack_o=1, then ->IDLE; a request still present in IDLE starts a new transfer, so minimum spacing between acks is 2 cycles.
REQ-022 Read (we=0): in the ACK cycle port_dat_o=buf[rd_ptr]; rd_ptr increments at the end of ACK, wrapping DEPTH-1->0.
REQ-023 port_dat_o holds its last value outside ACK.
REQ-024 Write (we=1): in the ACK cycle wr_valid_o=1 and wr_adr_o/wr_dat_o equal the request's adr/dat; rd_ptr is unchanged.
REQ-025 wr_adr_o/wr_dat_o hold until the next write.
REQ-026 Address, data and we are latched on request detection; changes during WAIT are ignored.
REQ-027 load_we_i writes buf[load_adr_i] on any cycle; when a load and a read ACK target the same entry in the same cycle, the read returns the old data.
REQ-028 Interrupt FSM states: COUNT, REQ, DONE; COUNT counts INT_PERIOD cycles, then ->REQ with int_req_o=1.
REQ-029 REQ holds int_req_o=1 until int_ack_i is sampled high, then clears the request and increments the issued count.
REQ-030 After the issued count is incremented: if count equals INT_COUNT and INT_COUNT≠0, ->DONE with int_done_o=1, permanent until reset; otherwise ->COUNT and restart the period.
REQ-031 int_ack_i sampled in COUNT or DONE is ignored.
REQ-032 The issued count saturates at its maximum when INT_COUNT=0.
REQ-033 The bus and interrupt FSMs are independent; simultaneous activity on both has no interaction.

Reset
REQ-034 While rst_i=0, and immediately (asynchronously): port_ack_o=0, wr_valid_o=0, int_req_o=0, int_done_o=0, port_dat_o=0, wr_adr_o=0, wr_dat_o=0.
REQ-035 Reset also sets rd_ptr=0, both FSMs to IDLE/COUNT, and all counters to 0.
REQ-036 Buffer contents are not reset.
REQ-037 A transfer in WAIT or ACK when reset asserts is abandoned with no ack after release.

Structure
REQ-038 Bus FSM and interrupt FSM state enums, and the WAIT width constant, are defined in shared package gumnut_port_pkg.
REQ-039 The interrupt generator is sub-module gumnut_int_gen, which carries INT_PERIOD and INT_COUNT.
REQ-040 The buffer is a plain register array with no vendor macro.

Verification
REQ-041 Preload buf[0..2]=A1,B2,C3, WAIT=0, three back-to-back reads -> acks 2 cycles apart returning A1,B2,C3, rd_ptr=3.
REQ-042 DEPTH=4, five reads -> fifth read returns buf[0] (wrap).
REQ-043 WAIT=3, write adr=05 dat=5A -> ack 4 cycles after request, one-cycle wr_valid_o, wr_adr_o=05, wr_dat_o=5A.
REQ-044 INT_PERIOD=25, INT_COUNT=2, ack delayed 7 cycles -> int_req_o high at cycle 25, held 7 cycles; second request 25 cycles after the first ack; int_done_o high after the second ack.
REQ-045 Stb dropped mid-WAIT -> no ack, rd_ptr unchanged; load to buf[rd_ptr] coincident with ACK -> old data returned.
REQ-046 rst_i low during WAIT -> outputs 0 immediately; no ack after release; rd_ptr=0.

Source files
------------

// File: rtl/gumnut_port_pkg.sv
// Shared types for the gumnut port responder: bus and interrupt FSM state
// encodings and the width of the bus wait-state counter.
package gumnut_port_pkg;

    // Wait counter holds WAIT-1, so WAIT values 0..15 fit in four bits.
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_ACK  = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        INT_ST_COUNT = 2'd0,
        INT_ST_REQ   = 2'd1,
        INT_ST_DONE  = 2'd2
    } int_state_e;

endpackage

// File: rtl/gumnut_int_gen.sv
// Periodic interrupt generator. Counts INT_PERIOD idle cycles, raises
// int_req_o until the CPU acknowledges it, and repeats. After INT_COUNT
// acknowledged interrupts it parks in DONE with int_done_o high; INT_COUNT=0
// means the sequence never ends.
//   clk_i      clock
//   rst_i      async active-low reset
//   int_ack_i  CPU interrupt acknowledge, only honoured while requesting
//   int_req_o  interrupt request (registered)
//   int_done_o all interrupts delivered (registered, sticky until reset)
module gumnut_int_gen
    import gumnut_port_pkg::*;
#(
    parameter int unsigned INT_PERIOD = 25,
    parameter int unsigned INT_COUNT  = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic int_ack_i,
    output logic int_req_o,
    output logic int_done_o
);

    localparam int unsigned PER_W = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
    localparam int unsigned CNT_W = (INT_COUNT == 0) ? 16 : $clog2(INT_COUNT + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(INT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    int_state_e       state_q, state_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    // Next-state logic for the interrupt sequencer.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        issued_d = issued_q;
        case (state_q)
            INT_ST_COUNT: begin
                if (period_q == PER_LAST) begin
                    state_d  = INT_ST_REQ;
                    period_d = '0;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end
            INT_ST_REQ: begin
                if (int_ack_i) begin
                    // Saturates only matters for the unlimited case.
                    if (issued_q != CNT_MAX) begin
                        issued_d = issued_q + 1'b1;
                    end
                    if ((INT_COUNT != 0) && (issued_q == CNT_LAST)) begin
                        state_d = INT_ST_DONE;
                    end else begin
                        state_d  = INT_ST_COUNT;
                        period_d = '0;
                    end
                end
            end
            INT_ST_DONE: begin
                state_d = INT_ST_DONE;
            end
            default: begin
                state_d  = INT_ST_COUNT;
                period_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= INT_ST_COUNT;
            period_q   <= '0;
            issued_q   <= '0;
            int_req_o  <= 1'b0;
            int_done_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            issued_q   <= issued_d;
            int_req_o  <= (state_d == INT_ST_REQ);
            int_done_o <= (state_d == INT_ST_DONE);
        end
    end

endmodule

// File: rtl/gumnut_port_responder.sv
// Gumnut I/O port responder. Answers CPU port cycles after an optional
// number of wait states: reads stream out of a preloadable buffer through a
// wrapping read pointer, writes are presented on the wr_* capture port. An
// independent interrupt generator exercises the CPU interrupt handshake.
//   clk_i, rst_i                 clock, async active-low reset
//   port_cyc_i/stb_i/we_i        CPU bus cycle, strobe, write enable
//   port_adr_i, port_dat_i       CPU address and write data
//   port_dat_o, port_ack_o       read data and transfer acknowledge
//   int_req_o, int_ack_i         interrupt request / acknowledge
//   int_done_o                   all interrupts delivered
//   load_we_i/adr_i/dat_i        buffer preload port (any cycle)
//   wr_valid_o, wr_adr_o/dat_o   captured CPU write
// DEPTH must be a power of two >= 2; WAIT must be 0..15.
module gumnut_port_responder
    import gumnut_port_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter int unsigned AW         = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WAIT       = 0,
    parameter int unsigned INT_PERIOD = 25,
    parameter int unsigned INT_COUNT  = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     port_cyc_i,
    input  logic                     port_stb_i,
    input  logic                     port_we_i,
    input  logic [AW-1:0]            port_adr_i,
    input  logic [DW-1:0]            port_dat_i,
    output logic [DW-1:0]            port_dat_o,
    output logic                     port_ack_o,
    output logic                     int_req_o,
    input  logic                     int_ack_i,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_adr_i,
    input  logic [DW-1:0]            load_dat_i,
    output logic                     wr_valid_o,
    output logic [AW-1:0]            wr_adr_o,
    output logic [DW-1:0]            wr_dat_o,
    output logic                     int_done_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    bus_state_e        bus_q, bus_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic              req_we_q;
    logic [AW-1:0]     req_adr_q;
    logic [DW-1:0]     req_dat_q;
    logic [DW-1:0]     buf_q [DEPTH];

    logic              request;
    logic              capture;
    logic              enter_ack;
    logic              eff_we;
    logic [AW-1:0]     eff_adr;
    logic [DW-1:0]     eff_dat;

    assign request = port_cyc_i & port_stb_i;

    // Bus transfer sequencer.
    always_comb begin
        bus_d   = bus_q;
        wait_d  = wait_q;
        capture = 1'b0;
        case (bus_q)
            BUS_IDLE: begin
                if (request) begin
                    capture = 1'b1;
                    if (WAIT == 0) begin
                        bus_d = BUS_ACK;
                    end else begin
                        bus_d  = BUS_WAIT;
                        wait_d = WAIT_W'(WAIT - 1);
                    end
                end
            end
            BUS_WAIT: begin
                // A withdrawn request abandons the transfer without side effects.
                if (!request) begin
                    bus_d = BUS_IDLE;
                end else if (wait_q == '0) begin
                    bus_d = BUS_ACK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            BUS_ACK: begin
                bus_d = BUS_IDLE;
            end
            default: begin
                bus_d = BUS_IDLE;
            end
        endcase
    end

    // With no wait states ACK is entered on the detection edge itself, so the
    // live inputs stand in for the not-yet-latched request fields.
    always_comb begin
        enter_ack = (bus_d == BUS_ACK);
        if (bus_q == BUS_IDLE) begin
            eff_we  = port_we_i;
            eff_adr = port_adr_i;
            eff_dat = port_dat_i;
        end else begin
            eff_we  = req_we_q;
            eff_adr = req_adr_q;
            eff_dat = req_dat_q;
        end
    end

    // Bus state, request latch, read pointer and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_q      <= BUS_IDLE;
            wait_q     <= '0;
            rd_ptr_q   <= '0;
            req_we_q   <= 1'b0;
            req_adr_q  <= '0;
            req_dat_q  <= '0;
            port_ack_o <= 1'b0;
            port_dat_o <= '0;
            wr_valid_o <= 1'b0;
            wr_adr_o   <= '0;
            wr_dat_o   <= '0;
        end else begin
            bus_q      <= bus_d;
            wait_q     <= wait_d;
            port_ack_o <= enter_ack;
            wr_valid_o <= enter_ack & eff_we;
            if (capture) begin
                req_we_q  <= port_we_i;
                req_adr_q <= port_adr_i;
                req_dat_q <= port_dat_i;
            end
            // Buffer read happens before any same-edge load lands: old data wins.
            if (enter_ack && !eff_we) begin
                port_dat_o <= buf_q[rd_ptr_q];
            end
            if (enter_ack && eff_we) begin
                wr_adr_o <= eff_adr;
                wr_dat_o <= eff_dat;
            end
            if ((bus_q == BUS_ACK) && !req_we_q) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Preload buffer; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            buf_q[load_adr_i] <= load_dat_i;
        end
    end

    gumnut_int_gen #(
        .INT_PERIOD (INT_PERIOD),
        .INT_COUNT  (INT_COUNT)
    ) u_int_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .int_ack_i  (int_ack_i),
        .int_req_o  (int_req_o),
        .int_done_o (int_done_o)
    );

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Bench for gumnut_port_responder. Instance A: no wait states, 4-entry buffer,
// two interrupts of period 25. Instance B: three wait states, 8-entry buffer,
// unlimited interrupts acknowledged immediately.
module tb_gumnut_port_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       cyc_a, stb_a, we_a, ack_a, ireq_a, iack_a, ld_we_a, wv_a, done_a;
    logic [7:0] adr_a, wdat_a, rdat_a, ld_dat_a, wadr_a, wcap_a;
    logic [1:0] ld_adr_a;

    logic       cyc_b, stb_b, we_b, ack_b, ireq_b, iack_b, ld_we_b, wv_b, done_b;
    logic [7:0] adr_b, wdat_b, rdat_b, ld_dat_b, wadr_b, wcap_b;
    logic [2:0] ld_adr_b;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b [8];
    int         ptr_a, ptr_b;
    int         tests, fails;

    assign iack_b = ireq_b;

    gumnut_port_responder #(
        .DW(8), .AW(8), .DEPTH(4), .WAIT(0), .INT_PERIOD(25), .INT_COUNT(2)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .port_cyc_i(cyc_a), .port_stb_i(stb_a), .port_we_i(we_a),
        .port_adr_i(adr_a), .port_dat_i(wdat_a),
        .port_dat_o(rdat_a), .port_ack_o(ack_a),
        .int_req_o(ireq_a), .int_ack_i(iack_a),
        .load_we_i(ld_we_a), .load_adr_i(ld_adr_a), .load_dat_i(ld_dat_a),
        .wr_valid_o(wv_a), .wr_adr_o(wadr_a), .wr_dat_o(wcap_a),
        .int_done_o(done_a)
    );

    gumnut_port_responder #(
        .DW(8), .AW(8), .DEPTH(8), .WAIT(3), .INT_PERIOD(3), .INT_COUNT(0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .port_cyc_i(cyc_b), .port_stb_i(stb_b), .port_we_i(we_b),
        .port_adr_i(adr_b), .port_dat_i(wdat_b),
        .port_dat_o(rdat_b), .port_ack_o(ack_b),
        .int_req_o(ireq_b), .int_ack_i(iack_b),
        .load_we_i(ld_we_b), .load_adr_i(ld_adr_b), .load_dat_i(ld_dat_b),
        .wr_valid_o(wv_b), .wr_adr_o(wadr_b), .wr_dat_o(wcap_b),
        .int_done_o(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers (called on a falling edge, return on a falling edge).
    task automatic load_a(input int idx, input logic [7:0] d);
        ld_we_a = 1'b1; ld_adr_a = 2'(idx); ld_dat_a = d;
        @(negedge clk);
        ld_we_a = 1'b0;
        mem_a[idx] = d;
    endtask

    task automatic load_b(input int idx, input logic [7:0] d);
        ld_we_b = 1'b1; ld_adr_b = 3'(idx); ld_dat_b = d;
        @(negedge clk);
        ld_we_b = 1'b0;
        mem_b[idx] = d;
    endtask

    task automatic read_a(output logic [7:0] rd, output int lat);
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin lat = i; rd = rdat_a; break; end
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer_b(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                          output logic [7:0] rd, output int lat, output logic wv,
                          output logic [7:0] wa, output logic [7:0] wd);
        cyc_b = 1'b1; stb_b = 1'b1; we_b = we; adr_b = adr; wdat_b = dat;
        lat = 0; rd = '0; wv = 1'b0; wa = '0; wd = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) begin
                lat = i; rd = rdat_b; wv = wv_b; wa = wadr_b; wd = wcap_b;
                break;
            end
        end
        cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({ack_a, wv_a, ireq_a, done_a, rdat_a, wadr_a, wcap_a} !== 28'h0) begin
            fails++; $display("FAIL reset_a: outputs %h expected 0",
                {ack_a, wv_a, ireq_a, done_a, rdat_a, wadr_a, wcap_a});
        end
        tests++;
        if ({ack_b, wv_b, ireq_b, done_b, rdat_b, wadr_b, wcap_b} !== 28'h0) begin
            fails++; $display("FAIL reset_b: outputs %h expected 0",
                {ack_b, wv_b, ireq_b, done_b, rdat_b, wadr_b, wcap_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ptr_a = 0; ptr_b = 0;
    endtask

    task automatic test_back_to_back();
        int         n_ack;
        int         ack_cyc [3];
        logic [7:0] ack_dat [3];
        logic [7:0] rd;
        int         lat;
        load_a(0, 8'hA1); load_a(1, 8'hB2); load_a(2, 8'hC3); load_a(3, 8'($urandom));
        n_ack = 0;
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                ack_cyc[n_ack] = i; ack_dat[n_ack] = rdat_a; n_ack++;
                if (n_ack == 3) break;
            end
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        tests++;
        if (n_ack != 3) begin fails++; $display("FAIL b2b_count: got %0d acks expected 3", n_ack); end
        for (int k = 0; k < n_ack; k++) begin
            tests++;
            if (ack_cyc[k] != 1 + 2 * k) begin
                fails++; $display("FAIL b2b_spacing[%0d]: ack at cycle %0d expected %0d", k, ack_cyc[k], 1 + 2 * k);
            end
            tests++;
            if (ack_dat[k] !== mem_a[(ptr_a + k) % 4]) begin
                fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, ack_dat[k], mem_a[(ptr_a + k) % 4]);
            end
        end
        ptr_a = (ptr_a + 3) % 4;
        @(negedge clk);
        tests++;
        if (ack_a !== 1'b0 || rdat_a !== 8'hC3) begin
            fails++; $display("FAIL dat_hold: ack %b dat %h expected ack 0 dat c3", ack_a, rdat_a);
        end
        // Fourth read proves the pointer reached 3, fifth proves the wrap; then random.
        for (int k = 0; k < 6; k++) begin
            read_a(rd, lat);
            tests++;
            if (lat != 1 || rd !== mem_a[ptr_a]) begin
                fails++; $display("FAIL read_a[%0d]: lat %0d data %h expected lat 1 data %h", k, lat, rd, mem_a[ptr_a]);
            end
            ptr_a = (ptr_a + 1) % 4;
            if (k == 1) load_a($urandom_range(0, 3), 8'($urandom));
        end
    endtask

    task automatic test_load_collision();
        int         e, lat;
        logic [7:0] old, x, y, rd;
        e = ptr_a; old = mem_a[e]; x = 8'($urandom); y = ~old;
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b0;
        ld_we_a = 1'b1; ld_adr_a = 2'(e); ld_dat_a = x;
        @(negedge clk);
        ld_dat_a = y;
        tests++;
        if (ack_a !== 1'b1 || rdat_a !== old) begin
            fails++; $display("FAIL load_collision: ack %b data %h expected ack 1 data %h", ack_a, rdat_a, old);
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        @(negedge clk);
        ld_we_a = 1'b0;
        mem_a[e] = y;
        ptr_a = (ptr_a + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            read_a(rd, lat);
            tests++;
            if (lat != 1 || rd !== mem_a[ptr_a]) begin
                fails++; $display("FAIL post_load[%0d]: lat %0d data %h expected lat 1 data %h", k, lat, rd, mem_a[ptr_a]);
            end
            ptr_a = (ptr_a + 1) % 4;
        end
    endtask

    task automatic test_write();
        int         lat;
        logic [7:0] rd, wa, wd, a, d;
        logic       wv;
        for (int i = 0; i < 8; i++) load_b(i, 8'($urandom));
        cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b1; adr_b = 8'h05; wdat_b = 8'h5A;
        lat = 0; wv = 1'b0; wa = '0; wd = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) begin lat = i; wv = wv_b; wa = wadr_b; wd = wcap_b; break; end
            adr_b = 8'($urandom); wdat_b = 8'($urandom);
        end
        cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0;
        tests++;
        if (lat != 4) begin fails++; $display("FAIL write_latency: ack after %0d cycles expected 4", lat); end
        tests++;
        if (wv !== 1'b1 || wa !== 8'h05 || wd !== 8'h5A) begin
            fails++; $display("FAIL write_capture: valid %b adr %h dat %h expected 1 05 5a", wv, wa, wd);
        end
        @(negedge clk);
        tests++;
        if (wv_b !== 1'b0 || ack_b !== 1'b0 || wadr_b !== 8'h05 || wcap_b !== 8'h5A) begin
            fails++; $display("FAIL write_hold: valid %b ack %b adr %h dat %h expected 0 0 05 5a", wv_b, ack_b, wadr_b, wcap_b);
        end
        xfer_b(1'b0, 8'h00, 8'h00, rd, lat, wv, wa, wd);
        tests++;
        if (lat != 4 || rd !== mem_b[ptr_b] || wv !== 1'b0) begin
            fails++; $display("FAIL write_no_ptr: lat %0d data %h wv %b expected 4 %h 0", lat, rd, wv, mem_b[ptr_b]);
        end
        ptr_b = (ptr_b + 1) % 8;
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom); d = 8'($urandom);
            xfer_b(1'b1, a, d, rd, lat, wv, wa, wd);
            tests++;
            if (lat != 4 || wv !== 1'b1 || wa !== a || wd !== d) begin
                fails++; $display("FAIL write_rand[%0d]: lat %0d valid %b adr %h dat %h expected 4 1 %h %h", k, lat, wv, wa, wd, a, d);
            end
        end
    endtask

    task automatic test_stb_drop();
        int         drop_at, n_ack, lat;
        logic [7:0] rd, wa, wd;
        logic       wv;
        drop_at = $urandom_range(1, 3);
        n_ack = 0;
        cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) n_ack++;
            if (i == drop_at) begin
                if ($urandom_range(0, 1) == 0) stb_b = 1'b0; else cyc_b = 1'b0;
            end
        end
        cyc_b = 1'b0; stb_b = 1'b0;
        tests++;
        if (n_ack != 0) begin fails++; $display("FAIL stb_drop_ack: got %0d acks expected 0", n_ack); end
        xfer_b(1'b0, 8'h00, 8'h00, rd, lat, wv, wa, wd);
        tests++;
        if (lat != 4 || rd !== mem_b[ptr_b]) begin
            fails++; $display("FAIL stb_drop_ptr: lat %0d data %h expected 4 %h", lat, rd, mem_b[ptr_b]);
        end
        ptr_b = (ptr_b + 1) % 8;
    endtask

    task automatic test_reset_in_wait();
        int         n_ack, lat;
        logic [7:0] rd, wa, wd;
        logic       wv;
        cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ack_b, wv_b, ireq_b, done_b, rdat_b, wadr_b, wcap_b} !== 28'h0) begin
            fails++; $display("FAIL reset_in_wait: outputs %h expected 0",
                {ack_b, wv_b, ireq_b, done_b, rdat_b, wadr_b, wcap_b});
        end
        tests++;
        if ({ack_a, wv_a, ireq_a, done_a, rdat_a, wadr_a, wcap_a} !== 28'h0) begin
            fails++; $display("FAIL reset_in_wait_a: outputs %h expected 0",
                {ack_a, wv_a, ireq_a, done_a, rdat_a, wadr_a, wcap_a});
        end
        @(negedge clk);
        cyc_b = 1'b0; stb_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_a = 0; ptr_b = 0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) n_ack++;
        end
        tests++;
        if (n_ack != 0) begin fails++; $display("FAIL reset_abandon: got %0d acks expected 0", n_ack); end
        xfer_b(1'b0, 8'h00, 8'h00, rd, lat, wv, wa, wd);
        tests++;
        if (lat != 4 || rd !== mem_b[0]) begin
            fails++; $display("FAIL reset_ptr: lat %0d data %h expected 4 %h", lat, rd, mem_b[0]);
        end
        ptr_b = 1;
    endtask

    task automatic test_interrupt();
        int d1, d2, rise1, a1, rise2, a2, total;
        d1 = 7; d2 = $urandom_range(1, 9);
        rise1 = 25; a1 = rise1 + d1; rise2 = a1 + 25; a2 = rise2 + d2; total = a2 + 8;
        iack_a = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_a = 0; ptr_b = 0;
        fork
            begin
                logic exp_req, exp_done;
                for (int n = 1; n <= total; n++) begin
                    @(negedge clk);
                    exp_req  = ((n >= rise1) && (n < a1)) || ((n >= rise2) && (n < a2));
                    exp_done = (n >= a2);
                    tests++;
                    if (ireq_a !== exp_req) begin
                        fails++; $display("FAIL int_req@%0d: got %b expected %b", n, ireq_a, exp_req);
                    end
                    tests++;
                    if (done_a !== exp_done) begin
                        fails++; $display("FAIL int_done@%0d: got %b expected %b", n, done_a, exp_done);
                    end
                    if (n == a1 - 1 || n == a2 - 1) iack_a = 1'b1;
                    else if (n < rise1 || (n >= a1 && n < rise2) || n >= a2) iack_a = 1'($urandom_range(0, 1));
                    else iack_a = 1'b0;
                end
                iack_a = 1'b0;
            end
            begin
                logic [7:0] rd;
                int         lat;
                for (int k = 0; k < 8; k++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    read_a(rd, lat);
                    tests++;
                    if (lat != 1 || rd !== mem_a[ptr_a]) begin
                        fails++; $display("FAIL int_bus_read[%0d]: lat %0d data %h expected 1 %h", k, lat, rd, mem_a[ptr_a]);
                    end
                    ptr_a = (ptr_a + 1) % 4;
                end
            end
        join
        tests++;
        if (done_b !== 1'b0) begin fails++; $display("FAIL int_unlimited: done %b expected 0", done_b); end
    endtask

    initial begin
        tests = 0; fails = 0;
        cyc_a = 0; stb_a = 0; we_a = 0; adr_a = 0; wdat_a = 0; iack_a = 0;
        ld_we_a = 0; ld_adr_a = 0; ld_dat_a = 0;
        cyc_b = 0; stb_b = 0; we_b = 0; adr_b = 0; wdat_b = 0;
        ld_we_b = 0; ld_adr_b = 0; ld_dat_b = 0;
        test_reset();
        test_back_to_back();
        test_load_collision();
        test_write();
        test_stb_drop();
        test_reset_in_wait();
        test_interrupt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
